// File: rtl/mem_ctrl.sv
// mem_ctrl: arbiter and byte-beat sequencer for the single byte-wide RAM port.
// The fetch path (4-byte word refill) and the load/store unit share the port.
// A granted request becomes 1, 2 or 4 byte beats; read bytes are reassembled
// little-endian and zero-extended above the access size.
//
// Ports
//   clk, rst      clock (rising edge), async active-low reset
//   rdy           run enable; 0 freezes every register and blocks mem_wr
//   mem_din       RAM read byte, valid one cycle after its address
//   mem_dout      RAM write byte
//   mem_a         RAM byte address (wraps modulo 2^ADDR_W)
//   mem_wr        RAM write strobe
//   if_req/if_addr/if_abort      fetch request, word address, redirect cancel
//   if_done/if_data              fetch completion pulse and word
//   ls_req/ls_we/ls_size/ls_addr/ls_wdata   load/store request
//   ls_done/ls_rdata             load/store completion pulse and load data
module mem_ctrl #(
   parameter int ADDR_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_abort,
   output logic              if_done,
   output logic [31:0]       if_data,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [1:0]        ls_size,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [31:0]       ls_wdata,
   output logic              ls_done,
   output logic [31:0]       ls_rdata
);

   localparam int CW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;

   state_t            state;
   logic [CW-1:0]     starve_cnt;
   logic [2:0]        beat;       // index of the edge about to happen, counted from the grant
   logic [2:0]        nbytes;
   logic [ADDR_W-1:0] base;
   logic [31:0]       wbuf;
   logic [3:0][7:0]   rbuf;
   logic              wr_q;

   logic              if_ok, ls_ok, if_win, ls_win;
   logic [2:0]        ls_n;
   logic [1:0]        lane;
   logic [3:0][7:0]   rbuf_nxt;
   logic [ADDR_W-1:0] beat_a;

   always_comb begin
      // A done pulse on either side forces one idle bubble before the next grant.
      if_ok    = if_req & ~if_abort & ~if_done & ~ls_done;
      ls_ok    = ls_req & ~if_done & ~ls_done;
      if_win   = if_ok & (~ls_ok | (starve_cnt == CW'(STARVE_MAX)));
      ls_win   = ls_ok & ~if_win;
      ls_n     = (ls_size == 2'd0) ? 3'd1 : (ls_size == 2'd1) ? 3'd2 : 3'd4;
      beat_a   = base + ADDR_W'(beat);
      // The byte addressed at edge E(i) arrives on mem_din in time for edge E(i+2).
      lane     = 2'(beat - 3'd2);
      rbuf_nxt = rbuf;
      if (beat >= 3'd2) rbuf_nxt[lane] = mem_din;
   end

   assign mem_wr = wr_q & rdy;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         starve_cnt <= '0;
         beat       <= '0;
         nbytes     <= '0;
         base       <= '0;
         wbuf       <= '0;
         rbuf       <= '0;
         wr_q       <= 1'b0;
         mem_a      <= '0;
         mem_dout   <= '0;
         if_done    <= 1'b0;
         if_data    <= '0;
         ls_done    <= 1'b0;
         ls_rdata   <= '0;
      end else if (rdy) begin
         if_done <= 1'b0;
         ls_done <= 1'b0;

         if (!if_req || (state == IDLE && if_win))
            starve_cnt <= '0;
         else if (state == IDLE && ls_win && starve_cnt != CW'(STARVE_MAX))
            starve_cnt <= starve_cnt + CW'(1);

         case (state)
            IDLE: begin
               if (if_win) begin
                  state  <= IF_RD;
                  base   <= if_addr;
                  mem_a  <= if_addr;
                  nbytes <= 3'd4;
                  beat   <= 3'd1;
                  rbuf   <= '0;
               end else if (ls_win) begin
                  base   <= ls_addr;
                  mem_a  <= ls_addr;
                  nbytes <= ls_n;
                  beat   <= 3'd1;
                  rbuf   <= '0;
                  wbuf   <= ls_wdata;
                  if (ls_we) begin
                     state    <= LS_WR;
                     mem_dout <= ls_wdata[7:0];
                     wr_q     <= 1'b1;
                  end else begin
                     state <= LS_RD;
                  end
               end
            end
            IF_RD, LS_RD: begin
               if (state == IF_RD && if_abort) begin
                  // Redirect: drop the partial word, no completion pulse.
                  state <= IDLE;
               end else begin
                  rbuf <= rbuf_nxt;
                  beat <= beat + 3'd1;
                  if (beat < nbytes) mem_a <= beat_a;
                  if (beat == nbytes + 3'd1) begin
                     state <= IDLE;
                     if (state == IF_RD) begin
                        if_done <= 1'b1;
                        if_data <= rbuf_nxt;
                     end else begin
                        ls_done  <= 1'b1;
                        ls_rdata <= rbuf_nxt;
                     end
                  end
               end
            end
            LS_WR: begin
               if (beat < nbytes) begin
                  mem_a    <= beat_a;
                  mem_dout <= wbuf[8*beat[1:0] +: 8];
                  beat     <= beat + 3'd1;
               end else begin
                  wr_q    <= 1'b0;
                  ls_done <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
   localparam int SMAX = 2;

   logic        clk = 1'b0, rst = 1'b0, rdy = 1'b0;
   logic [7:0]  mem_din, mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        if_req = 1'b0, if_abort = 1'b0, if_done;
   logic [31:0] if_addr = '0, if_data;
   logic        ls_req = 1'b0, ls_we = 1'b0, ls_done;
   logic [1:0]  ls_size = '0;
   logic [31:0] ls_addr = '0, ls_wdata = '0, ls_rdata;

   int checks = 0, errors = 0;

   logic [7:0] ram     [0:65535];
   logic [7:0] ref_mem [0:65535];
   bit         ram_init = 1'b0;

   mem_ctrl #(.ADDR_W(32), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .mem_din(mem_din), .mem_dout(mem_dout),
      .mem_a(mem_a), .mem_wr(mem_wr), .if_req(if_req), .if_addr(if_addr),
      .if_abort(if_abort), .if_done(if_done), .if_data(if_data), .ls_req(ls_req),
      .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_done(ls_done), .ls_rdata(ls_rdata));

   always #5 clk = ~clk;

   function automatic logic [7:0] init_byte(int i);
      case (i)
         'h100:        return 8'h13;
         'h101:        return 8'h05;
         'h102, 'h103: return 8'h00;
         default:      return 8'(i * 37 + (i >> 5) * 11 + 5);
      endcase
   endfunction

   // Byte-wide synchronous RAM, stalled together with the controller.
   always @(posedge clk) begin
      if (!ram_init) begin
         for (int i = 0; i < 65536; i++) ram[i] <= init_byte(i);
         ram_init <= 1'b1;
      end else if (rdy) begin
         mem_din <= ram[mem_a[15:0]];
         if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
      end
   end

   // Expected little-endian load value from the reference memory.
   function automatic logic [31:0] ref_load(logic [31:0] a, int n);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[16'(a + 32'(i))];
      return v;
   endfunction

   task automatic test_reset();
      #12;
      checks++; if (mem_wr !== 1'b0)    begin errors++; $display("FAIL reset_mem_wr got %b exp 0", mem_wr); end
      checks++; if (mem_a !== 32'h0)    begin errors++; $display("FAIL reset_mem_a got %h exp 0", mem_a); end
      checks++; if (mem_dout !== 8'h0)  begin errors++; $display("FAIL reset_mem_dout got %h exp 0", mem_dout); end
      checks++; if ({if_done, ls_done} !== 2'b00) begin errors++; $display("FAIL reset_done got %b exp 00", {if_done, ls_done}); end
      checks++; if ({if_data, ls_rdata} !== 64'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {if_data, ls_rdata}); end
      rdy = 1'b1;
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if ({mem_wr, if_done, ls_done} !== 3'b000) begin errors++; $display("FAIL idle_after_reset got %b exp 000", {mem_wr, if_done, ls_done}); end
   endtask

   task automatic test_fetch();
      if_addr = 32'h100;
      if_req  = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 8; k++) begin
         if (k < 4) begin
            checks++; if (mem_a !== 32'h100 + 32'(k)) begin errors++; $display("FAIL fetch_addr k=%0d got %h exp %h", k, mem_a, 32'h100 + 32'(k)); end
         end
         checks++; if (if_done !== 1'(k == 5)) begin errors++; $display("FAIL fetch_done k=%0d got %b exp %b", k, if_done, k == 5); end
         checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL fetch_mem_wr k=%0d got %b exp 0", k, mem_wr); end
         if (k == 5) begin
            checks++; if (if_data !== 32'h0000_0513) begin errors++; $display("FAIL fetch_data got %h exp 00000513", if_data); end
            if_req = 1'b0;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_store_half();
      ls_we = 1'b1; ls_size = 2'd1; ls_addr = 32'h2001; ls_wdata = 32'h0000_BEEF;
      ls_req = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
         if (k == 0) begin
            checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h2001, 8'hEF}) begin errors++; $display("FAIL store_beat0 got %b %h %h exp 1 00002001 ef", mem_wr, mem_a, mem_dout); end
         end else if (k == 1) begin
            checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h2002, 8'hBE}) begin errors++; $display("FAIL store_beat1 got %b %h %h exp 1 00002002 be", mem_wr, mem_a, mem_dout); end
         end else begin
            checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL store_wr_after k=%0d got %b exp 0", k, mem_wr); end
         end
         checks++; if (ls_done !== 1'(k == 2)) begin errors++; $display("FAIL store_done k=%0d got %b exp %b", k, ls_done, k == 2); end
         if (k == 2) ls_req = 1'b0;
         @(posedge clk); #1;
      end
      ref_mem[16'h2001] = 8'hEF;
      ref_mem[16'h2002] = 8'hBE;
      checks++; if ({ram[16'h2001], ram[16'h2002]} !== 16'hEFBE) begin errors++; $display("FAIL store_ram got %h%h exp efbe", ram[16'h2001], ram[16'h2002]); end
   endtask

   task automatic test_ls_random();
      logic        we;
      logic [1:0]  sz;
      logic [31:0] a, wd, exp;
      int          n, lat;
      for (int it = 0; it < 16; it++) begin
         we = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         a  = 32'($urandom_range(16'h0800, 16'hFFF0));
         wd = $urandom;
         if (it == 5) begin we = 1'b1; sz = 2'd2; a = 32'hFFFF_FFFE; end
         if (it == 6) begin we = 1'b0; sz = 2'd3; a = 32'hFFFF_FFFE; end
         n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
         lat = we ? n : n + 1;
         exp = ref_load(a, n);
         ls_we = we; ls_size = sz; ls_addr = a; ls_wdata = wd; ls_req = 1'b1;
         @(posedge clk); #1;
         for (int k = 0; k <= lat + 1; k++) begin
            if (we && k < n) begin
               checks++;
               if ({mem_wr, mem_a, mem_dout} !== {1'b1, a + 32'(k), wd[8*k +: 8]}) begin
                  errors++; $display("FAIL rnd_store it=%0d k=%0d got %b %h %h exp 1 %h %h", it, k, mem_wr, mem_a, mem_dout, a + 32'(k), wd[8*k +: 8]);
               end
               ref_mem[16'(a + 32'(k))] = wd[8*k +: 8];
            end
            checks++; if (ls_done !== 1'(k == lat)) begin errors++; $display("FAIL rnd_done it=%0d k=%0d got %b exp %b", it, k, ls_done, k == lat); end
            if (k == lat) begin
               ls_req = 1'b0;
               if (!we) begin
                  checks++; if (ls_rdata !== exp) begin errors++; $display("FAIL rnd_load it=%0d got %h exp %h", it, ls_rdata, exp); end
               end
            end
            @(posedge clk); #1;
         end
         if (we) for (int i = 0; i < n; i++) begin
            checks++;
            if (ram[16'(a + 32'(i))] !== ref_mem[16'(a + 32'(i))]) begin
               errors++; $display("FAIL rnd_ram it=%0d i=%0d got %h exp %h", it, i, ram[16'(a + 32'(i))], ref_mem[16'(a + 32'(i))]);
            end
         end
      end
   endtask

   task automatic test_starve();
      int got, waited;
      bit exp_if;
      got = 0; waited = 0;
      if_addr = 32'h100; ls_we = 1'b0; ls_size = 2'd0; ls_addr = 32'h300;
      if_req = 1'b1; ls_req = 1'b1;
      for (int c = 0; c < 200 && got < 6; c++) begin
         @(posedge clk); #1;
         if (if_done || ls_done) begin
            exp_if = (waited == SMAX);
            waited = exp_if ? 0 : waited + 1;
            checks++;
            if ({if_done, ls_done} !== {exp_if, !exp_if}) begin
               errors++; $display("FAIL starve_order n=%0d got if=%b ls=%b exp if=%b", got, if_done, ls_done, exp_if);
            end
            got++;
         end
      end
      if_req = 1'b0; ls_req = 1'b0;
      checks++; if (got != 6) begin errors++; $display("FAIL starve_timeout got %0d dones exp 6", got); end
      @(posedge clk); #1;
   endtask

   task automatic test_abort();
      logic [31:0] exp;
      exp = ref_load(32'h500, 4);
      if_addr = 32'h400; if_req = 1'b1;
      @(posedge clk); #1;
      ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h500; ls_req = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if (k == 2) begin
            checks++; if (mem_a !== 32'h402) begin errors++; $display("FAIL abort_addr got %h exp 00000402", mem_a); end
            if_abort = 1'b1;
         end
         if (k == 3) begin if_abort = 1'b0; if_req = 1'b0; end
         checks++; if ({if_done, mem_wr} !== 2'b00) begin errors++; $display("FAIL abort_quiet k=%0d got %b exp 00", k, {if_done, mem_wr}); end
         checks++; if (ls_done !== 1'(k == 9)) begin errors++; $display("FAIL abort_ls_done k=%0d got %b exp %b", k, ls_done, k == 9); end
         if (k == 9) begin
            checks++; if (ls_rdata !== exp) begin errors++; $display("FAIL abort_ls_data got %h exp %h", ls_rdata, exp); end
            ls_req = 1'b0;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] wd;
      wd = $urandom;
      ls_we = 1'b1; ls_size = 2'd2; ls_addr = 32'h600; ls_wdata = wd; ls_req = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if ({mem_wr, mem_a} !== {1'b1, 32'h601}) begin errors++; $display("FAIL rmid_beat1 got %b %h exp 1 00000601", mem_wr, mem_a); end
      #2 rst = 1'b0;
      #1;
      checks++; if ({mem_wr, mem_a, mem_dout} !== 41'h0) begin errors++; $display("FAIL rmid_async got %b %h %h exp all 0", mem_wr, mem_a, mem_dout); end
      checks++; if ({if_done, ls_done, if_data, ls_rdata} !== 66'h0) begin errors++; $display("FAIL rmid_outs got %b %b %h %h exp all 0", if_done, ls_done, if_data, ls_rdata); end
      ls_req = 1'b0;
      #1 rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         checks++; if ({ls_done, mem_wr} !== 2'b00) begin errors++; $display("FAIL rmid_after k=%0d got %b exp 00", k, {ls_done, mem_wr}); end
      end
      ref_mem[16'h600] = wd[7:0];
      checks++; if ({ram[16'h600], ram[16'h601]} !== {ref_mem[16'h600], ref_mem[16'h601]}) begin
         errors++; $display("FAIL rmid_ram got %h%h exp %h%h", ram[16'h600], ram[16'h601], ref_mem[16'h600], ref_mem[16'h601]);
      end
   endtask

   task automatic test_rdy_stall();
      logic [31:0] exp, wd;
      exp = ref_load(32'h700, 4);
      ls_we = 1'b0; ls_size = 2'd2; ls_addr = 32'h700; ls_req = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 11; k++) begin
         if (k == 2) rdy = 1'b0;
         if (k == 5) rdy = 1'b1;
         checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL stall_ld_wr k=%0d got %b exp 0", k, mem_wr); end
         checks++; if (ls_done !== 1'(k == 8)) begin errors++; $display("FAIL stall_ld_done k=%0d got %b exp %b", k, ls_done, k == 8); end
         if (k == 8) begin
            checks++; if (ls_rdata !== exp) begin errors++; $display("FAIL stall_ld_data got %h exp %h", ls_rdata, exp); end
            ls_req = 1'b0;
         end
         @(posedge clk); #1;
      end
      wd = $urandom;
      ls_we = 1'b1; ls_addr = 32'h780; ls_wdata = wd; ls_req = 1'b1;
      @(posedge clk); #1;
      rdy = 1'b0; #1;
      checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL stall_st_gate got %b exp 0", mem_wr); end
      @(posedge clk); #1;
      checks++; if ({mem_wr, mem_a} !== {1'b0, 32'h780}) begin errors++; $display("FAIL stall_st_hold got %b %h exp 0 00000780", mem_wr, mem_a); end
      rdy = 1'b1; #1;
      checks++; if ({mem_wr, mem_dout} !== {1'b1, wd[7:0]}) begin errors++; $display("FAIL stall_st_resume got %b %h exp 1 %h", mem_wr, mem_dout, wd[7:0]); end
      for (int j = 1; j <= 4; j++) begin
         @(posedge clk); #1;
         if (j < 4) begin
            checks++; if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h780 + 32'(j), wd[8*j +: 8]}) begin
               errors++; $display("FAIL stall_st_beat j=%0d got %b %h %h exp 1 %h %h", j, mem_wr, mem_a, mem_dout, 32'h780 + 32'(j), wd[8*j +: 8]);
            end
         end else begin
            checks++; if ({ls_done, mem_wr} !== 2'b10) begin errors++; $display("FAIL stall_st_done got %b exp 10", {ls_done, mem_wr}); end
            ls_req = 1'b0;
         end
      end
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         ref_mem[16'h780 + 16'(i)] = wd[8*i +: 8];
         checks++; if (ram[16'h780 + 16'(i)] !== wd[8*i +: 8]) begin errors++; $display("FAIL stall_st_ram i=%0d got %h exp %h", i, ram[16'h780 + 16'(i)], wd[8*i +: 8]); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
      test_reset();
      test_fetch();
      test_store_half();
      test_ls_random();
      test_starve();
      test_abort();
      test_reset_mid();
      test_rdy_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
